// File: rtl/ei_pe_pkg.sv
// ei_pe_pkg
//   Shared types and widths for the PE datapath blocks.
//   ACC_W : accumulator / result width
//   OP_W  : operand width fed to the 8x8 MAC
//   mac_seq_state_t : sequencer states, IDLE -> CLEAR -> ISSUE -> DRAIN -> HOLD
package ei_pe_pkg;

    localparam int unsigned ACC_W = 32;
    localparam int unsigned OP_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE,
        DRAIN,
        HOLD
    } mac_seq_state_t;

endpackage

// File: rtl/ei_mac_seq_ctrl.sv
// ei_mac_seq_ctrl
//   Sequencer for one ei_mac8x8_pipe dot-product engine. On start it clears the MAC
//   accumulator, reads len operand pairs from a 1-cycle-latency RAM, streams them into
//   the MAC, waits for the pipeline to drain and holds the 32-bit sum on a valid/ready
//   output. A drain watchdog flags a sticky err if the products never all arrive.
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   start, len               job request (len captured in IDLE, clamped to MAX_LEN)
//   busy                     job in progress (start accepted, result not yet taken)
//   op_rd_en, op_addr        operand RAM read port; op_a/op_b return one cycle later
//   mac_rst, mac_en          MAC control derived from rst_n
//   mac_valid_in, mac_clr_acc, mac_a, mac_b   MAC inputs
//   mac_acc_out, mac_valid_out                MAC outputs
//   res_data, res_valid, res_ready            result handshake
//   err                      sticky drain timeout
module ei_mac_seq_ctrl
    import ei_pe_pkg::*;
#(
    parameter  int unsigned LAT     = 3,
    parameter  int unsigned MAX_LEN = 256,
    localparam int unsigned ADDR_W  = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              op_rd_en,
    output logic [ADDR_W-1:0] op_addr,
    input  logic [OP_W-1:0]   op_a,
    input  logic [OP_W-1:0]   op_b,
    output logic              mac_rst,
    output logic              mac_en,
    output logic              mac_valid_in,
    output logic              mac_clr_acc,
    output logic [OP_W-1:0]   mac_a,
    output logic [OP_W-1:0]   mac_b,
    input  logic [ACC_W-1:0]  mac_acc_out,
    input  logic              mac_valid_out,
    output logic [ACC_W-1:0]  res_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              err
);

    localparam int unsigned     WD_W      = $clog2(LAT + 4) + 1;
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(LAT + 3);
    localparam logic [ADDR_W:0] MAX_LEN_L = (ADDR_W + 1)'(MAX_LEN);

    mac_seq_state_t    state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [ACC_W-1:0]  res_q, res_d;
    logic              err_q, err_d;
    logic              rd_q;
    logic              vin_q;
    logic [OP_W-1:0]   a_q, b_q;

    logic [ADDR_W:0]   len_eff;
    logic              last_addr;

    assign len_eff   = (len > MAX_LEN_L) ? MAX_LEN_L : len;
    assign last_addr = ({1'b0, addr_q} == (len_q - (ADDR_W + 1)'(1)));

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        res_d   = res_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = len_eff;
                    err_d   = 1'b0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                addr_d = '0;
                wd_d   = '0;
                if (len_q != '0) begin
                    state_d = ISSUE;
                end else begin
                    res_d   = '0;
                    state_d = HOLD;
                end
            end
            ISSUE: begin
                if (last_addr) begin
                    wd_d    = '0;
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                wd_d = wd_q + 1'b1;
                // cnt_q is registered, so the accumulator already includes the last product.
                if (cnt_q == len_q) begin
                    res_d   = mac_acc_out;
                    state_d = HOLD;
                end else if (wd_q == WD_LAST) begin
                    err_d   = 1'b1;
                    res_d   = mac_acc_out;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Products are counted for the whole job; IDLE keeps the counter cleared.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (mac_valid_out) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            wd_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            vin_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            res_q   <= res_d;
            err_q   <= err_d;
            // rd_q marks RAM data valid; it is registered together with the operands so
            // valid_in and a/b reach the MAC in the same cycle.
            rd_q    <= op_rd_en;
            vin_q   <= rd_q;
            if (rd_q) begin
                a_q <= op_a;
                b_q <= op_b;
            end
        end
    end

    assign busy         = (state_q != IDLE);
    assign op_rd_en     = (state_q == ISSUE);
    assign op_addr      = addr_q;
    assign mac_rst      = ~rst_n;
    assign mac_en       = rst_n;
    assign mac_valid_in = vin_q;
    assign mac_clr_acc  = (state_q == CLEAR);
    assign mac_a        = a_q;
    assign mac_b        = b_q;
    assign res_data     = res_q;
    assign res_valid    = (state_q == HOLD);
    assign err          = err_q;

endmodule

// File: tb/tb_ei_mac_seq_ctrl.sv
// tb_ei_mac_seq_ctrl
//   Sequencer with a behavioural LAT=3 MAC and a 1-cycle operand RAM. Each job pushes its
//   expected sum/err/latency to a queue; the entry is popped when res_valid appears.
module tb_ei_mac_seq_ctrl;
    import ei_pe_pkg::*;

    localparam int unsigned LAT     = 3;
    localparam int unsigned MAX_LEN = 256;
    localparam int unsigned ADDR_W  = 8;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   len = '0;
    logic              busy, op_rd_en;
    logic [ADDR_W-1:0] op_addr;
    logic [7:0]        op_a = '0, op_b = '0;
    logic              mac_rst, mac_en, mac_valid_in, mac_clr_acc;
    logic [7:0]        mac_a, mac_b;
    logic [31:0]       mac_acc_out;
    logic              mac_valid_out;
    logic [31:0]       res_data;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic              err;

    logic [7:0]        ram_a [MAX_LEN];
    logic [7:0]        ram_b [MAX_LEN];
    logic              kill_vo = 1'b0;
    logic [LAT-1:0]    vpipe;
    logic [15:0]       ppipe [LAT];

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    ei_mac_seq_ctrl #(
        .LAT     (LAT),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .len           (len),
        .busy          (busy),
        .op_rd_en      (op_rd_en),
        .op_addr       (op_addr),
        .op_a          (op_a),
        .op_b          (op_b),
        .mac_rst       (mac_rst),
        .mac_en        (mac_en),
        .mac_valid_in  (mac_valid_in),
        .mac_clr_acc   (mac_clr_acc),
        .mac_a         (mac_a),
        .mac_b         (mac_b),
        .mac_acc_out   (mac_acc_out),
        .mac_valid_out (mac_valid_out),
        .res_data      (res_data),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .err           (err)
    );

    // Operand RAM: registered read.
    always_ff @(posedge clk) begin
        if (op_rd_en) begin
            op_a <= ram_a[op_addr];
            op_b <= ram_b[op_addr];
        end
    end

    // Behavioural MAC: valid_out LAT cycles after valid_in, acc updates on the edge ending
    // the valid_out cycle, clr_acc has priority. kill_vo suppresses valid_out.
    assign mac_valid_out = vpipe[LAT-1] & ~kill_vo;

    always_ff @(posedge clk) begin
        if (mac_rst) begin
            vpipe       <= '0;
            mac_acc_out <= '0;
            for (int i = 0; i < LAT; i++) ppipe[i] <= '0;
        end else if (mac_en) begin
            vpipe    <= {vpipe[LAT-2:0], mac_valid_in};
            ppipe[0] <= 16'(mac_a) * 16'(mac_b);
            for (int i = 1; i < LAT; i++) ppipe[i] <= ppipe[i-1];
            if (mac_clr_acc) mac_acc_out <= '0;
            else if (mac_valid_out) mac_acc_out <= mac_acc_out + 32'(ppipe[LAT-1]);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // mode 0: a=i+1, b=i+5; mode 1: all 255; mode 2: random
    task automatic fill(input int mode);
        for (int i = 0; i < MAX_LEN; i++) begin
            case (mode)
                0:       begin ram_a[i] = 8'(i + 1); ram_b[i] = 8'(i + 5); end
                1:       begin ram_a[i] = 8'hff;     ram_b[i] = 8'hff;     end
                default: begin ram_a[i] = 8'($urandom_range(0, 255));
                               ram_b[i] = 8'($urandom_range(0, 255)); end
            endcase
        end
    endtask

    task automatic run_job(input int n_req, input int mode, input bit kill, input int hold);
        int          n;
        int          lat;
        int          rd_cnt;
        logic [31:0] sum;
        exp_t        e;
        n   = (n_req > MAX_LEN) ? MAX_LEN : n_req;
        fill(mode);
        sum = '0;
        for (int i = 0; i < n; i++) sum += 32'(ram_a[i]) * 32'(ram_b[i]);
        e.data = kill ? 32'd0 : sum;
        e.err  = kill;
        e.lat  = (n == 0) ? 2 : (kill ? n + LAT + 6 : n + LAT + 5);
        exp_q.push_back(e);

        kill_vo   = kill;
        res_ready = (hold == 0);
        len       = (ADDR_W + 1)'(n_req);
        start     = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        lat    = 1;
        rd_cnt = 0;
        check_val("busy_after_start", 32'(busy), 32'd1);
        check_val("err_cleared_on_start", 32'(err), 32'd0);
        while (!res_valid && lat < 2000) begin
            if (op_rd_en) rd_cnt++;
            @(negedge clk);
            lat++;
        end
        if (!res_valid) check_val("res_valid_timeout", 32'd0, 32'd1);
        e = exp_q.pop_front();
        check_val($sformatf("res_data_len%0d", n_req), res_data, e.data);
        check_val($sformatf("err_len%0d", n_req), 32'(err), 32'(e.err));
        check_val($sformatf("latency_len%0d", n_req), 32'(lat), 32'(e.lat));
        check_val($sformatf("reads_len%0d", n_req), 32'(rd_cnt), 32'(n));

        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                start = 1'b1;
                len   = (ADDR_W + 1)'(1);
                @(negedge clk);
                check_val("hold_res_valid", 32'(res_valid), 32'd1);
                check_val("hold_res_data", res_data, e.data);
                check_val("hold_busy", 32'(busy), 32'd1);
            end
            // start stays high through the handoff edge and must be ignored there.
            res_ready = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end else begin
            @(negedge clk);
        end
        check_val("busy_after_handoff", 32'(busy), 32'd0);
        check_val("res_valid_after_handoff", 32'(res_valid), 32'd0);
        kill_vo = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int guard;
        repeat (3) @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_res_valid", 32'(res_valid), 32'd0);
        check_val("rst_mac_rst", 32'(mac_rst), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("idle_mac_en", 32'(mac_en), 32'd1);
        check_val("idle_op_rd_en", 32'(op_rd_en), 32'd0);

        run_job(4, 0, 1'b0, 0);      // 70, latency 12
        run_job(0, 0, 1'b0, 0);      // empty vector
        run_job(1, 1, 1'b0, 0);      // 65025
        run_job(256, 1, 1'b0, 0);    // 16646400, no wrap
        run_job(511, 1, 1'b0, 0);    // clamped to MAX_LEN
        run_job(2, 2, 1'b0, 20);     // result held, starts ignored
        run_job(5, 2, 1'b0, 0);      // next start accepted after hold

        // Reset for one cycle mid-ISSUE.
        fill(2);
        len   = (ADDR_W + 1)'(5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(op_rd_en && op_addr == 8'd2) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_val("reached_addr2", 32'(op_addr), 32'd2);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_op_rd_en", 32'(op_rd_en), 32'd0);
        check_val("mid_rst_op_addr", 32'(op_addr), 32'd0);
        check_val("mid_rst_mac_valid_in", 32'(mac_valid_in), 32'd0);
        check_val("mid_rst_mac_clr_acc", 32'(mac_clr_acc), 32'd0);
        check_val("mid_rst_mac_a", 32'(mac_a), 32'd0);
        check_val("mid_rst_mac_b", 32'(mac_b), 32'd0);
        check_val("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check_val("mid_rst_res_data", res_data, 32'd0);
        check_val("mid_rst_err", 32'(err), 32'd0);
        check_val("mid_rst_mac_rst", 32'(mac_rst), 32'd1);
        check_val("mid_rst_mac_en", 32'(mac_en), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_job(3, 2, 1'b0, 0);      // no stale products

        run_job(3, 2, 1'b1, 0);      // watchdog: err=1, res_data=0
        run_job(4, 2, 1'b0, 0);      // err cleared by next start

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
